// File: rtl/bcd_exc_3_if.sv
// Button/LED bundle for the BCD to Excess-3 converter.
//   BTN : raw 4-bit BCD digit from the push-buttons (asynchronous to clk)
//   LED : registered Excess-3 code of the accepted digit
//   ERR : registered flag, 1 when the accepted digit is 10..15
interface bcd_exc_3_if;
  logic [3:0] BTN;
  logic [3:0] LED;
  logic       ERR;

  modport master (output BTN, input LED, input ERR);
  modport slave  (input BTN, output LED, output ERR);
endinterface

// File: rtl/bcd_exc_3.sv
// BCD to Excess-3 converter: synchronises and debounces the button digit,
// then registers its Excess-3 code onto the LEDs and flags non-BCD digits.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset, clears every register
//   io  : slave side of bcd_exc_3_if (BTN in, LED/ERR out)
// Latency BTN -> LED/ERR is SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges.
module bcd_exc_3 #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  bcd_exc_3_if.slave  io
);

  localparam int unsigned DIG_W = 4;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  // Each synchroniser stage carries a valid bit so that the cleared reset
  // contents are never mistaken for a real digit of 0.
  logic [SYNC_STAGES-1:0][DIG_W-1:0] sync_q;
  logic [SYNC_STAGES-1:0]            sync_vld_q;

  logic [DIG_W-1:0] prev_q;
  logic             prev_vld_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIG_W-1:0] a_q;
  logic             a_vld_q;
  logic [DIG_W-1:0] led_q;
  logic             err_q;

  logic [DIG_W-1:0] s_c;
  logic             s_vld_c;
  logic             changed_c;
  logic [CNT_W-1:0] cnt_nxt_c;
  logic             load_c;
  logic [DIG_W-1:0] led_nxt_c;
  logic             err_nxt_c;

  // Synchroniser chain, BTN enters at stage 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      sync_vld_q <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], io.BTN};
      sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Stability counter: restarts at 1 on any change of s, saturates at the
  // debounce length; a loads on the edge where the count reaches it.
  always_comb begin
    s_vld_c   = sync_vld_q[SYNC_STAGES-1];
    s_c       = sync_q[SYNC_STAGES-1];
    changed_c = !prev_vld_q || (s_c != prev_q);
    cnt_nxt_c = '0;
    if (!s_vld_c) begin
      cnt_nxt_c = '0;
    end else if (changed_c) begin
      cnt_nxt_c = CNT_W'(1);
    end else if (cnt_q >= CNT_MAX) begin
      cnt_nxt_c = CNT_MAX;
    end else begin
      cnt_nxt_c = cnt_q + CNT_W'(1);
    end
    load_c = s_vld_c && (cnt_nxt_c == CNT_MAX);
  end

  // Debounce state and accepted digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      cnt_q      <= '0;
      a_q        <= '0;
      a_vld_q    <= 1'b0;
    end else begin
      prev_q     <= s_c;
      prev_vld_q <= s_vld_c;
      cnt_q      <= cnt_nxt_c;
      if (load_c) begin
        a_q     <= s_c;
        a_vld_q <= 1'b1;
      end
    end
  end

  // Excess-3 code for 0..9; non-BCD digits give 0000 with the error flag.
  always_comb begin
    led_nxt_c = '0;
    err_nxt_c = 1'b1;
    if (a_q <= DIG_W'(9)) begin
      led_nxt_c = a_q + DIG_W'(3);
      err_nxt_c = 1'b0;
    end
  end

  // Output registers; held at 0000 until a real digit has been accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
      err_q <= 1'b0;
    end else if (a_vld_q) begin
      led_q <= led_nxt_c;
      err_q <= err_nxt_c;
    end
  end

  assign io.LED = led_q;
  assign io.ERR = err_q;

endmodule

// File: tb/tb_bcd_exc_3.sv
// Directed self-checking bench for bcd_exc_3: one default instance, one with
// an 8-edge debounce and one with a 3-stage synchroniser. Outputs are sampled
// 1 time unit after each rising edge; observed/expected values are {ERR,LED}.
module tb_bcd_exc_3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bcd_exc_3_if if_a ();
  bcd_exc_3_if if_d ();
  bcd_exc_3_if if_s ();

  bcd_exc_3 #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .io(if_a));
  bcd_exc_3 #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)) dut_d (.clk(clk), .rst(rst), .io(if_d));
  bcd_exc_3 #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut_s (.clk(clk), .rst(rst), .io(if_s));

  always #5 clk = ~clk;

  // Hand-computed {ERR,LED} for digits 0..15.
  logic [4:0] exp_tab [16] = '{5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
                               5'h0B, 5'h0C, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive the default instance and check old value at edge 3, new at edge 4.
  task automatic apply_a(input logic [3:0] v, input logic [4:0] old_exp,
                         input logic [4:0] new_exp, input string tag);
    if_a.BTN = v;
    repeat (3) tick();
    chk({tag, "_edge3"}, {if_a.ERR, if_a.LED}, old_exp);
    tick();
    chk({tag, "_edge4"}, {if_a.ERR, if_a.LED}, new_exp);
  endtask

  initial begin
    if_a.BTN = 4'b0101;
    if_d.BTN = 4'b0000;
    if_s.BTN = 4'b0000;

    // Reset held with BTN = 0101.
    #2 rst = 1'b1;
    #1 chk("rst_async", {if_a.ERR, if_a.LED}, 5'h00);
    repeat (3) tick();
    chk("rst_hold", {if_a.ERR, if_a.LED}, 5'h00);
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk($sformatf("rst_rel_e%0d", e), {if_a.ERR, if_a.LED}, 5'h00);
    end
    tick();
    chk("rst_rel_e4", {if_a.ERR, if_a.LED}, 5'h08);

    // Sweep 0..15, one per clock; output for step m seen 4 edges later.
    for (int i = 0; i <= 18; i++) begin
      if (i < 16) if_a.BTN = 4'(i);
      tick();
      if (i >= 3) chk($sformatf("sweep_%0d", i - 3), {if_a.ERR, if_a.LED}, exp_tab[i - 3]);
    end

    // Boundary digits with exact latency.
    apply_a(4'd9,  5'h10, 5'h0C, "bnd_9");
    apply_a(4'd10, 5'h0C, 5'h10, "bnd_10");
    apply_a(4'd0,  5'h10, 5'h03, "bnd_0");

    // Debounce 8: settled on 0, then a 3-cycle pulse of 0111 is filtered.
    chk("db_idle", {if_d.ERR, if_d.LED}, 5'h03);
    if_d.BTN = 4'b0111;
    repeat (3) tick();
    if_d.BTN = 4'b0000;
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk($sformatf("db_glitch_e%0d", e), {if_d.ERR, if_d.LED}, 5'h03);
    end
    // Held 0111: LED updates 11 edges after the change.
    if_d.BTN = 4'b0111;
    repeat (10) tick();
    chk("db_hold_e10", {if_d.ERR, if_d.LED}, 5'h03);
    tick();
    chk("db_hold_e11", {if_d.ERR, if_d.LED}, 5'h0A);

    // Three synchroniser stages: 0000 -> 0011 shows 0110 five edges later.
    chk("s3_idle", {if_s.ERR, if_s.LED}, 5'h03);
    if_s.BTN = 4'b0011;
    repeat (4) tick();
    chk("s3_e4", {if_s.ERR, if_s.LED}, 5'h03);
    tick();
    chk("s3_e5", {if_s.ERR, if_s.LED}, 5'h06);

    // Asynchronous reset mid-stream while LED = 1001 and digit 3 is in flight.
    if_a.BTN = 4'd6;
    repeat (4) tick();
    chk("mid_pre", {if_a.ERR, if_a.LED}, 5'h09);
    if_a.BTN = 4'd3;
    repeat (2) tick();
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_a", {if_a.ERR, if_a.LED}, 5'h00);
    chk("mid_rst_d", {if_d.ERR, if_d.LED}, 5'h00);
    chk("mid_rst_s", {if_s.ERR, if_s.LED}, 5'h00);
    if_a.BTN = 4'd0;
    repeat (2) tick();
    chk("mid_rst_hold", {if_a.ERR, if_a.LED}, 5'h00);
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk($sformatf("mid_rel_e%0d", e), {if_a.ERR, if_a.LED}, 5'h00);
    end
    tick();
    chk("mid_rel_e4", {if_a.ERR, if_a.LED}, 5'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
